// File: rtl/max_unpooling_stream_if.sv
// Handshake bundle for the 2x2 max-unpooling stream:
// pooled values in, full-resolution pixels out.
interface max_unpooling_stream_if #(
  parameter int DATA_BITS = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;
  logic [1:0]           in_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_last;

  modport master (
    output in_valid, in_data, in_idx, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_idx, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/max_unpooling_stream.sv
// Streaming 2x2 max-unpooling: buffers one pooled row,
// then expands it into two output rows with zero fill.
module max_unpooling_stream #(
  parameter int DATA_BITS = 32,
  parameter int W         = 46,
  parameter int H         = 46
) (
  input logic                   clk,
  input logic                   rst,
  max_unpooling_stream_if.slave bus
);
  localparam int IW  = (W > 2) ? $clog2(W / 2) : 1;
  localparam int OCW = $clog2(W);
  localparam int PW  = (H > 2) ? $clog2(H / 2) : 1;

  localparam logic [IW-1:0]  IN_LAST  = IW'(W / 2 - 1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(W - 1);
  localparam logic [PW-1:0]  P_LAST   = PW'(H / 2 - 1);

  typedef enum logic [1:0] {
    FILL,
    EMIT_TOP,
    EMIT_BOT
  } state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [1:0]           idx;
  } entry_t;

  state_t          state;
  state_t          state_nx;
  entry_t          row_buf [W/2];
  entry_t          rd;
  logic [IW-1:0]   rd_idx;
  logic [IW-1:0]   in_col;
  logic [OCW-1:0]  out_col;
  logic [PW-1:0]   prow;
  logic            in_fire;
  logic            out_fire;

  assign rd_idx   = IW'(out_col >> 1);
  assign rd       = row_buf[rd_idx];
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    unique case (state)
      FILL: begin
        bus.in_ready = !rst;
        if (bus.in_valid && !rst && in_col == IN_LAST)
          state_nx = EMIT_TOP;
      end
      EMIT_TOP: begin
        bus.out_valid = 1'b1;
        if (rd.idx == {1'b0, out_col[0]})
          bus.out_data = rd.data;
        if (bus.out_ready && out_col == OUT_LAST)
          state_nx = EMIT_BOT;
      end
      EMIT_BOT: begin
        bus.out_valid = 1'b1;
        if (rd.idx == {1'b1, out_col[0]})
          bus.out_data = rd.data;
        bus.out_last = (prow == P_LAST) &&
                       (out_col == OUT_LAST);
        if (bus.out_ready && out_col == OUT_LAST)
          state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_col  <= '0;
      out_col <= '0;
      prow    <= '0;
    end else begin
      if (in_fire)
        in_col <= (in_col == IN_LAST) ? '0
                : in_col + IW'(1);
      if (out_fire) begin
        if (out_col == OUT_LAST) begin
          out_col <= '0;
          if (state == EMIT_BOT)
            prow <= (prow == P_LAST) ? '0
                  : prow + PW'(1);
        end else begin
          out_col <= out_col + OCW'(1);
        end
      end
    end
  end

  // Buffer holds no reset: stale entries are always rewritten before reuse.
  always_ff @(posedge clk) begin
    if (in_fire)
      row_buf[in_col] <= '{data: bus.in_data,
                           idx:  bus.in_idx};
  end
endmodule

// File: tb/tb_max_unpooling_stream.sv
// Scoreboard bench for max_unpooling_stream (W=4, H=4):
// random pooled rows vs. a row-expansion reference model.
module tb_max_unpooling_stream;
  localparam int DB = 32;
  localparam int W  = 4;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  max_unpooling_stream_if #(.DATA_BITS(DB)) bus ();

  max_unpooling_stream #(
    .DATA_BITS(DB), .W(W), .H(H)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_n    = -10;
  int hs_n     = -10;
  int hs_count = 0;
  int mode     = 0;
  int pat_k    = 0;
  bit bypass   = 1'b0;

  logic [DB:0]    exp_q[$];
  logic [DB+1:0]  pend[$];
  int             prow_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [DB:0] act,
                       logic [DB:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: once a pooled row is complete, emit its 2 x W pixels.
  task automatic model_push(logic [DB-1:0] d, logic [1:0] i);
    logic [DB+1:0] e;
    logic [DB-1:0] v;
    pend.push_back({d, i});
    if (pend.size() == W / 2) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < W; c++) begin
          e = pend[c / 2];
          v = (int'(e[1:0]) == r * 2 + c % 2) ? e[DB+1:2] : '0;
          exp_q.push_back({(prow_m == H / 2 - 1 && r == 1
                            && c == W - 1), v});
        end
      pend.delete();
      prow_m = (prow_m + 1) % (H / 2);
    end
  endtask

  task automatic send(logic [DB-1:0] d, logic [1:0] i,
                      bit use_model);
    int t = 0;
    if (use_model) model_push(d, i);
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_idx   = i;
        acc_n = cyc;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        return;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_idx   = 2'($urandom_range(0, 3));
      t++;
      if (t > 500) begin
        failures++;
        $display("FAIL send_timeout: in_ready never rose");
        bus.in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 || bus.out_valid) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        failures++;
        $display("FAIL drain_timeout: %0d pending", exp_q.size());
        return;
      end
    end
  endtask

  task automatic send_rows(int n);
    for (int k = 0; k < n * (W / 2); k++)
      send($urandom, 2'($urandom_range(0, 3)), 1'b1);
  endtask

  // Monitor: owns out_ready so its value is known when checking.
  logic          prev_stall = 1'b0;
  logic          prev_ov    = 1'b0;
  logic [DB:0]   prev_out   = '0;
  logic [DB:0]   got;
  logic [1:0]    pat;

  always @(negedge clk) begin
    pat = (pat_k % 4 == 0 || pat_k % 4 == 3) ? 2'd1 : 2'd0;
    pat_k++;
    case (mode)
      1:       bus.out_ready = pat[0];
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b1;
    endcase
    got = {bus.out_last, bus.out_data};
    if (rst) begin
      prev_stall = 1'b0;
      prev_ov    = 1'b0;
    end else begin
      if (prev_stall) check("stall_stable", got, prev_out);
      if (bus.out_valid)
        check("in_ready_in_emit", 33'(bus.in_ready), 33'd0);
      if (!bypass && !prev_ov && bus.out_valid)
        check("first_pixel_latency", 33'(cyc), 33'(acc_n + 1));
      if (!bypass && prev_ov && !bus.out_valid) begin
        check("valid_drop_timing", 33'(cyc), 33'(hs_n + 1));
        check("in_ready_after_emit", 33'(bus.in_ready), 33'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_count++;
        hs_n = cyc;
        if (!bypass) begin
          if (exp_q.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL unexpected_pixel: got %0h", got);
          end else begin
            check("pixel", got, exp_q.pop_front());
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_ov    = bus.out_valid;
      prev_out   = got;
    end
  end

  initial begin
    int base;
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hdead_beef;
    bus.in_idx   = 2'd3;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", 33'(bus.in_ready), 33'd0);
      check("rst_out_valid", 33'(bus.out_valid), 33'd0);
      check("rst_out", {bus.out_last, bus.out_data}, 33'd0);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1 check("post_rst_in_ready", 33'(bus.in_ready), 33'd1);

    // Directed placement: one full map, all four argmax codes.
    send(32'd10, 2'd0, 1'b1);
    send(32'd20, 2'd3, 1'b1);
    send(32'd7,  2'd1, 1'b1);
    send(32'd9,  2'd2, 1'b1);
    wait_drain();

    mode = 1;
    send_rows(4);
    wait_drain();

    mode = 2;
    send_rows(6);
    wait_drain();

    // Reset in the middle of the top row after two pixels.
    mode   = 0;
    bypass = 1'b1;
    base   = hs_count;
    send(32'd11, 2'd1, 1'b0);
    send(32'd12, 2'd2, 1'b0);
    t = 0;
    while (hs_count < base + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("mid_rst_reached", 33'(hs_count >= base + 2), 33'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check("mid_rst_out_valid", 33'(bus.out_valid), 33'd0);
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    exp_q.delete();
    prow_m = 0;
    bypass = 1'b0;
    send(32'd5, 2'd0, 1'b1);
    send(32'd6, 2'd0, 1'b1);
    send_rows(1);
    mode = 2;
    send_rows(2);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
